// File: rtl/softex_pkg.sv
// rtl/softex_pkg.sv - shared types and helpers for the SoftEx TCDM splitter
package softex_pkg;

    localparam int unsigned TCDM_LANE_W = 32;

    typedef struct packed {
        logic [31:0] add;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] data;
    } tcdm_lane_req_t;

    // Lane addresses wrap modulo 2^32, so plain 32-bit addition is intended.
    function automatic logic [31:0] lane_addr(input logic [31:0] base, input int unsigned lane);
        return base + 32'(lane * 4);
    endfunction

endpackage

// File: rtl/softex_tcdm_rsp_fifo.sv
// rtl/softex_tcdm_rsp_fifo.sv - registered response FIFO with synchronous clear
module softex_tcdm_rsp_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o   = (r_wptr == r_rptr);
    assign full_o    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign data_o    = r_mem[r_rptr[AW-1:0]];
    assign w_do_push = push_i & ~full_o & ~clear_i;
    assign w_do_pop  = pop_i & ~empty_o & ~clear_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (clear_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && !clear_i && push_i) assert (!full_o);
    end

endmodule

// File: rtl/softex_tcdm_splitter.sv
// rtl/softex_tcdm_splitter.sv - wide-to-narrow TCDM splitter with per-lane grant tracking
module softex_tcdm_splitter
    import softex_pkg::*;
#(
    parameter int unsigned DW        = 256,
    parameter int unsigned MP        = DW / 32,
    parameter int unsigned IW        = 8,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              in_req_i,
    output logic              in_gnt_o,
    input  logic [31:0]       in_add_i,
    input  logic              in_wen_i,
    input  logic [DW/8-1:0]   in_be_i,
    input  logic [DW-1:0]     in_data_i,
    input  logic [IW-1:0]     in_id_i,
    output logic              in_r_valid_o,
    input  logic              in_r_ready_i,
    output logic [DW-1:0]     in_r_data_o,
    output logic [IW-1:0]     in_r_id_o,
    output logic [MP-1:0]     out_req_o,
    input  logic [MP-1:0]     out_gnt_i,
    output logic [MP*32-1:0]  out_add_o,
    output logic [MP-1:0]     out_wen_o,
    output logic [MP*4-1:0]   out_be_o,
    output logic [MP*32-1:0]  out_data_o,
    input  logic [MP-1:0]     out_r_valid_i,
    input  logic [MP*32-1:0]  out_r_data_i,
    output logic [MP-1:0]     out_r_ready_o,
    output logic              busy_o
);
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

    logic [MP-1:0] r_done;
    logic [CW-1:0] r_cnt;
    logic          w_credit_ok;
    logic [MP-1:0] w_lane_gnt;
    logic [MP-1:0] w_lane_empty;
    logic          w_id_empty;
    logic          w_id_full;
    logic [MP-1:0] w_lane_full;
    logic          w_pop;

    assign w_credit_ok   = (r_cnt < CW'(RSP_DEPTH));
    assign out_req_o     = {MP{in_req_i & w_credit_ok}} & ~r_done;
    assign w_lane_gnt    = out_gnt_i & out_req_o;
    assign in_gnt_o      = in_req_i & w_credit_ok & (&(r_done | w_lane_gnt));
    assign in_r_valid_o  = (&(~w_lane_empty)) & ~w_id_empty;
    assign w_pop         = in_r_valid_o & in_r_ready_i;
    assign out_r_ready_o = '1;
    assign busy_o        = (r_cnt != '0) | (|r_done);

    for (genvar i = 0; i < MP; i++) begin : g_lane
        tcdm_lane_req_t w_lane;

        assign w_lane.add  = lane_addr(in_add_i, i);
        assign w_lane.wen  = in_wen_i;
        assign w_lane.be   = in_be_i[4*i +: 4];
        assign w_lane.data = in_data_i[TCDM_LANE_W*i +: TCDM_LANE_W];

        assign out_add_o[32*i +: 32]  = w_lane.add;
        assign out_wen_o[i]           = w_lane.wen;
        assign out_be_o[4*i +: 4]     = w_lane.be;
        assign out_data_o[32*i +: 32] = w_lane.data;

        softex_tcdm_rsp_fifo #(.WIDTH(TCDM_LANE_W), .DEPTH(RSP_DEPTH)) u_lane_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (clear_i),
            .push_i  (out_r_valid_i[i]),
            .data_i  (out_r_data_i[32*i +: 32]),
            .pop_i   (w_pop),
            .data_o  (in_r_data_o[32*i +: 32]),
            .empty_o (w_lane_empty[i]),
            .full_o  (w_lane_full[i])
        );
    end

    softex_tcdm_rsp_fifo #(.WIDTH(IW), .DEPTH(RSP_DEPTH)) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (in_gnt_o),
        .data_i  (in_id_i),
        .pop_i   (w_pop),
        .data_o  (in_r_id_o),
        .empty_o (w_id_empty),
        .full_o  (w_id_full)
    );

    // Credit counter bounds outstanding wide transactions so no FIFO can overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done <= '0;
            r_cnt  <= '0;
        end else if (clear_i) begin
            r_done <= '0;
            r_cnt  <= '0;
        end else begin
            if (in_gnt_o) r_done <= '0;
            else          r_done <= r_done | w_lane_gnt;
            if (in_gnt_o && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!in_gnt_o && w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_softex_tcdm_splitter.sv
// tb/tb_softex_tcdm_splitter.sv - randomized scoreboard bench for softex_tcdm_splitter
module tb_softex_tcdm_splitter;
    localparam int DW = 256;
    localparam int MP = 8;
    localparam int IW = 8;
    localparam int RD = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              in_req_i = 1'b0;
    logic              in_gnt_o;
    logic [31:0]       in_add_i = '0;
    logic              in_wen_i = 1'b0;
    logic [DW/8-1:0]   in_be_i = '0;
    logic [DW-1:0]     in_data_i = '0;
    logic [IW-1:0]     in_id_i = '0;
    logic              in_r_valid_o;
    logic              in_r_ready_i = 1'b0;
    logic [DW-1:0]     in_r_data_o;
    logic [IW-1:0]     in_r_id_o;
    logic [MP-1:0]     out_req_o;
    logic [MP-1:0]     out_gnt_i = '0;
    logic [MP*32-1:0]  out_add_o;
    logic [MP-1:0]     out_wen_o;
    logic [MP*4-1:0]   out_be_o;
    logic [MP*32-1:0]  out_data_o;
    logic [MP-1:0]     out_r_valid_i = '0;
    logic [MP*32-1:0]  out_r_data_i = '0;
    logic [MP-1:0]     out_r_ready_o;
    logic              busy_o;

    always #5 clk = ~clk;

    softex_tcdm_splitter #(.DW(DW), .MP(MP), .IW(IW), .RSP_DEPTH(RD)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i), .in_wen_i(in_wen_i),
        .in_be_i(in_be_i), .in_data_i(in_data_i), .in_id_i(in_id_i),
        .in_r_valid_o(in_r_valid_o), .in_r_ready_i(in_r_ready_i),
        .in_r_data_o(in_r_data_o), .in_r_id_o(in_r_id_o),
        .out_req_o(out_req_o), .out_gnt_i(out_gnt_i), .out_add_o(out_add_o),
        .out_wen_o(out_wen_o), .out_be_o(out_be_o), .out_data_o(out_data_o),
        .out_r_valid_i(out_r_valid_i), .out_r_data_i(out_r_data_i),
        .out_r_ready_o(out_r_ready_o), .busy_o(busy_o)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_gnt = 0;
    int n_dut_gnt = 0;

    // Reference model state: what the splitter should hold, in transaction terms.
    logic [MP-1:0] m_done = '0;
    int m_cnt = 0;
    int m_id = 0;
    int m_lane[MP];
    bit drop_req = 1'b0;
    bit wrap_next = 1'b0;

    // Per-lane in-order memory response pipes.
    logic [31:0] ring_d[MP][16];
    int ring_due[MP][16];
    int rh[MP];
    int rt[MP];
    int last_due[MP];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rsp_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic model_reset();
        m_done = '0;
        m_cnt = 0;
        m_id = 0;
        drop_req = 1'b0;
        sb.delete();
        for (int i = 0; i < MP; i++) begin
            m_lane[i] = 0;
            rh[i] = 0;
            rt[i] = 0;
            last_due[i] = 0;
        end
    endtask

    task automatic new_request();
        in_req_i = 1'b1;
        in_add_i = wrap_next ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
        wrap_next = 1'b0;
        in_wen_i = $urandom_range(0, 1);
        in_be_i = $urandom;
        for (int k = 0; k < MP; k++) in_data_i[32*k +: 32] = $urandom;
        in_id_i = $urandom;
    endtask

    task automatic cycle(input int gnt_pct, input int rdy_pct, input bit req_on);
        logic [MP-1:0] exp_req;
        logic [MP-1:0] lane_g;
        logic [MP-1:0] lane_rsp;
        logic [31:0]   a;
        logic          exp_gnt;
        logic          exp_rv;
        logic          pop;
        exp_t          e;
        int            due;
        @(negedge clk);
        cyc++;
        if (drop_req) begin
            in_req_i = 1'b0;
            drop_req = 1'b0;
        end
        if (!in_req_i && req_on) new_request();
        for (int i = 0; i < MP; i++) begin
            lane_rsp[i] = 1'b0;
            out_r_valid_i[i] = 1'b0;
            if (rh[i] != rt[i] && ring_due[i][rh[i] % 16] <= cyc) begin
                out_r_valid_i[i] = 1'b1;
                out_r_data_i[32*i +: 32] = ring_d[i][rh[i] % 16];
                rh[i]++;
                lane_rsp[i] = 1'b1;
            end
        end
        in_r_ready_i = ($urandom % 100) < rdy_pct;
        #1;
        exp_req = (in_req_i && m_cnt < RD) ? ~m_done : '0;
        chk("out_req", out_req_o, exp_req);
        chk("busy", busy_o, (m_cnt != 0) || (|m_done));
        exp_rv = (m_id > 0);
        for (int i = 0; i < MP; i++) if (m_lane[i] == 0) exp_rv = 1'b0;
        chk("r_valid", in_r_valid_o, exp_rv);
        chk("r_ready", out_r_ready_o, {MP{1'b1}});
        for (int i = 0; i < MP; i++) out_gnt_i[i] = exp_req[i] && (($urandom % 100) < gnt_pct);
        #1;
        lane_g = out_gnt_i & exp_req;
        exp_gnt = in_req_i && (m_cnt < RD) && (&(m_done | lane_g));
        chk("in_gnt", in_gnt_o, exp_gnt);
        if (in_gnt_o) n_dut_gnt++;
        for (int i = 0; i < MP; i++) begin
            if (lane_g[i]) begin
                a = in_add_i + 32'(4 * i);
                chk("lane_add", out_add_o[32*i +: 32], a);
                chk("lane_be", out_be_o[4*i +: 4], in_be_i[4*i +: 4]);
                chk("lane_data", out_data_o[32*i +: 32], in_data_i[32*i +: 32]);
                chk("lane_wen", out_wen_o[i], in_wen_i);
                due = cyc + 1 + $urandom_range(0, 4);
                if (due <= last_due[i]) due = last_due[i] + 1;
                last_due[i] = due;
                ring_d[i][rt[i] % 16] = rsp_word(a);
                ring_due[i][rt[i] % 16] = due;
                rt[i]++;
            end
        end
        pop = exp_rv && in_r_ready_i;
        if (exp_gnt) begin
            for (int i = 0; i < MP; i++) e.data[32*i +: 32] = rsp_word(in_add_i + 32'(4 * i));
            e.id = in_id_i;
            sb.push_back(e);
            m_id++;
            m_done = '0;
            drop_req = 1'b1;
            n_gnt++;
        end else begin
            m_done = m_done | lane_g;
        end
        for (int i = 0; i < MP; i++) m_lane[i] += (lane_rsp[i] ? 1 : 0) - (pop ? 1 : 0);
        m_cnt += (exp_gnt ? 1 : 0) - (pop ? 1 : 0);
        if (pop) m_id--;
    endtask

    task automatic drain();
        int t = 0;
        while ((in_req_i || m_cnt != 0) && t < 500) begin
            cycle(100, 100, 1'b0);
            t++;
        end
        cycle(100, 100, 1'b0);
        chk("drain_busy", busy_o, 1'b0);
        chk("drain_sb_left", sb.size(), 0);
    endtask

    // Monitor: compares every accepted wide response against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && in_r_valid_o && in_r_ready_i) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp actual_id=%h required=none", in_r_id_o);
                end else begin
                    e = sb.pop_front();
                    chk("r_data", in_r_data_o, e.data);
                    chk("r_id", in_r_id_o, e.id);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_r_valid", in_r_valid_o, 1'b0);
        chk("reset_out_req", out_req_o, '0);
        chk("reset_r_ready", out_r_ready_o, {MP{1'b1}});

        wrap_next = 1'b1;
        while (n_gnt < 150 && cyc < 6000) cycle(60, 70, 1'b1);
        drain();

        g0 = n_dut_gnt;
        repeat (12) cycle(100, 0, 1'b1);
        chk("credit_grants", n_dut_gnt - g0, 4);
        cycle(100, 100, 1'b1);
        cycle(100, 0, 1'b1);
        drain();

        repeat (2) cycle(100, 0, 1'b1);
        cycle(50, 0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_r_valid", in_r_valid_o, 1'b0);
        in_req_i = 1'b0;
        out_gnt_i = '0;
        out_r_valid_i = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        g0 = n_gnt;
        while (n_gnt - g0 < 40 && cyc < 12000) cycle(70, 80, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/softex_tcdm_splitter.md
# softex_tcdm_splitter

Splits one wide TCDM request port of the SoftEx accelerator into MP independent 32-bit TCDM master ports and reassembles the responses into one wide response. Narrow ports are granted independently: each granted lane is tracked, instead of requiring all grants in the same cycle. Responses that return on different cycles per lane are absorbed in per-lane FIFOs, bounded by a credit counter. Sits between the SoftEx streamer's wide TCDM interface and the cluster interconnect, replacing the fixed-binding wrapper logic.

## Interface
- DW, 256: wide data width in bits; multiple of 32.
- MP, DW/32: number of 32-bit narrow ports.
- IW, 8: transaction ID width.
- RSP_DEPTH, 4: per-lane response FIFO depth and max outstanding wide transactions; power of 2, ≥2.
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous flush of all state.
- in_req_i / in_gnt_o  in/out  1  wide request / grant.
- in_add_i  in  32  byte address of lane 0.
- in_wen_i  in  1  1 = read, 0 = write (TCDM convention).
- in_be_i  in  DW/8  byte enables.
- in_data_i  in  DW  write data.
- in_id_i  in  IW  transaction ID.
- in_r_valid_o / in_r_ready_i  out/in  1  wide response handshake.
- in_r_data_o  out  DW  reassembled read data.
- in_r_id_o  out  IW  ID of the returned transaction.
- out_req_o / out_gnt_i  out/in  MP  per-lane request / grant.
- out_add_o  out  MP×32  lane address.
- out_wen_o  out  MP  lane write enable.
- out_be_o  out  MP×4  lane byte enables.
- out_data_o  out  MP×32  lane write data.
- out_r_valid_i  in  MP  lane response valid.
- out_r_data_i  in  MP×32  lane response data.
- out_r_ready_o  out  MP  constant 1; never back-pressures.
- busy_o  out  1  high while any transaction is outstanding or partially granted.

## Operation
- State:
  - done_q[MP]: lanes already granted for the current wide request.
  - cnt_q: outstanding wide transactions, 0..RSP_DEPTH.
  - MP lane data FIFOs.
  - One ID FIFO, depth RSP_DEPTH, width IW.
- credit_ok = cnt_q < RSP_DEPTH.
- out_req_o[i] = in_req_i & credit_ok & ~done_q[i].
- Lane payload:
  - out_add_o[i] = in_add_i + 4·i, modulo 2^32.
  - be = in_be_i[4i+:4]; data = in_data_i[32i+:32].
  - wen is broadcast to all lanes.
- in_gnt_o = in_req_i & credit_ok & &(done_q | (out_gnt_i & out_req_o)).
- On in_gnt_o:
  - done_q ← 0.
  - in_id_i is pushed into the ID FIFO.
  - cnt_q increments.
- Otherwise done_q |= out_gnt_i & out_req_o.
- A lane that has been granted drops its out_req_o until the wide grant completes.
- The master must hold in_req_i and its payload stable until in_gnt_o.
- Every narrow grant (read or write) returns exactly one out_r_valid_i. The lane FIFO pushes out_r_data_i on it.
- Credit guarantees no lane FIFO overflows. A push into a full FIFO is an assertion error.
- in_r_valid_o = all lane FIFOs non-empty & ID FIFO non-empty.
- in_r_data_o is the concatenation of lane FIFO heads, lane 0 at LSBs. in_r_id_o is the ID FIFO head.
- Pop all FIFOs on in_r_valid_o & in_r_ready_i; cnt_q decrements.
- Simultaneous wide grant and pop leave cnt_q unchanged.
- clear_i sets done_q=0, cnt_q=0 and empties all FIFOs. out_r_valid_i is ignored in the clear cycle.
- clear_i is legal only when no responses are still in flight; the issuer guarantees this.
- busy_o = (cnt_q≠0) | (|done_q).

## Timing
- Reset:
  - done_q=0, cnt_q=0, FIFOs empty.
  - Hence in_r_valid_o=0 and busy_o=0.
  - out_req_o and in_gnt_o follow in_req_i combinationally (credit_ok=1).
  - out_r_ready_o=1.
- Reset mid-operation discards all state immediately; partial grants are lost.
- Request path is combinational: a wide grant occurs in the same cycle as the last lane grant.
- Response latency: in_r_valid_o rises the cycle after the last lane's out_r_valid_i. FIFOs are registered, not fall-through.
- Full credit (cnt_q=RSP_DEPTH): all out_req_o=0 and in_gnt_o=0 until a pop. A pop in the same cycle does not re-enable requests until the next cycle.
- Once any lane is granted, credit_ok cannot fall before the wide grant, because only pops change cnt_q in that interval.

## Structure
- softex_pkg gets:
  - tcdm_lane_req_t struct: add, wen, be, data.
  - Constant TCDM_LANE_W = 32.
- One sub-module, softex_tcdm_rsp_fifo:
  - Parametrised width/depth, synchronous clear.
  - Used MP times for data (width 32) and once for ID (width IW).

## Test plan
- All lanes grant together, read at 0x1000, responses 2 cycles later → in_gnt_o in the same cycle; lane i address 0x1000+4i; in_r_data_o assembled in lane order, ID echoed.
- MP=8 with lanes 0–3 granted at cycle 0 and lanes 4–7 at cycle 3 → lanes 0–3 drop req from cycle 1; in_gnt_o only at cycle 3; no lane is re-requested.
- Lane responses skewed across cycles 5..9 → in_r_valid_o first at cycle 10 with the correct data.
- RSP_DEPTH=4, in_r_ready_i=0, continuous requests → exactly 4 wide grants, then out_req_o=0. One pop re-enables requests the next cycle. IDs return in order.
- Address 0xFFFF_FFF8 with MP=4 → lane addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- rst_ni asserted with 2 outstanding transactions and a partial grant → busy_o=0, in_r_valid_o=0, cnt_q=0. A new request after reset proceeds normally.
